// File: rtl/mem_cache_pkg.sv
// mem_cache_pkg: shared types and geometry for the two-way write-through data cache.
package mem_cache_pkg;

  localparam int SETS         = 64;
  localparam int INDEX_W      = 6;
  localparam int TAG_W        = 10;
  localparam int WORD_SEL_BIT = 2;
  localparam int WAYS         = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MISS0 = 3'd1,
    MISS1 = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      word1;
    logic [31:0]      word0;
  } line_t;

  // Set index sits just above the word-select bit.
  function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] eff);
    return eff[WORD_SEL_BIT+INDEX_W:WORD_SEL_BIT+1];
  endfunction

  // Tag sits just above the set index; higher bits are ignored.
  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] eff);
    return eff[WORD_SEL_BIT+INDEX_W+TAG_W:WORD_SEL_BIT+INDEX_W+1];
  endfunction

endpackage

// File: rtl/mem_cache_array.sv
// mem_cache_array: valid/tag/data/LRU storage for both ways, hit compare,
// line fill into the LRU victim and single-word write on a hit.
module mem_cache_array
  import mem_cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] index,
  input  logic [TAG_W-1:0]   tag,
  input  logic               word_sel,
  output logic               hit,
  output logic               hit_way,
  output logic [31:0]        hit_word,
  output logic               victim_way,
  input  logic               touch,
  input  logic               fill_en,
  input  logic [31:0]        fill_word0,
  input  logic [31:0]        fill_word1,
  input  logic               wr_en,
  input  logic [31:0]        wr_data
);

  line_t [WAYS-1:0] way_line;
  logic  [WAYS-1:0] way_hit;
  logic  [SETS-1:0] lru_q;

  assign victim_way = lru_q[index];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [TAG_W-1:0] tag_mem [SETS];
    logic [31:0]      w0_mem  [SETS];
    logic [31:0]      w1_mem  [SETS];
    logic [SETS-1:0]  valid_q;
    logic             fill_this;
    logic             wr_this;

    assign way_line[w] = '{valid: valid_q[index], tag: tag_mem[index],
                           word1: w1_mem[index], word0: w0_mem[index]};
    assign way_hit[w]  = way_line[w].valid && (way_line[w].tag == tag);
    assign fill_this   = fill_en && (victim_way == 1'(w));
    assign wr_this     = wr_en && way_hit[w];

    // Valid bits are the only per-line state cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         valid_q        <= '0;
      else if (fill_this) valid_q[index] <= 1'b1;
    end

    // Tag/data storage: whole-line fill or single-word write-through update.
    always_ff @(posedge clk) begin
      if (fill_this) begin
        tag_mem[index] <= tag;
        w0_mem[index]  <= fill_word0;
        w1_mem[index]  <= fill_word1;
      end else if (wr_this) begin
        if (word_sel) w1_mem[index] <= wr_data;
        else          w0_mem[index] <= wr_data;
      end
    end
  end

  // At most one way can match since fills always replace the victim.
  always_comb begin
    hit      = |way_hit;
    hit_way  = way_hit[1];
    hit_word = word_sel ? way_line[hit_way].word1 : way_line[hit_way].word0;
  end

  // LRU names the next victim: the way not just filled or touched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       lru_q        <= '0;
    else if (fill_en)                 lru_q[index] <= ~victim_way;
    else if ((touch || wr_en) && hit) lru_q[index] <= ~hit_way;
  end

endmodule

// File: rtl/mem_cache.sv
// mem_cache: two-way set-associative, write-through, read-allocate data cache.
// Holds the FSM, address split and SRAM handshake; storage lives in
// mem_cache_array. Optional hit/miss counters with MEM_CACHE_STATS_EN.
module mem_cache
  import mem_cache_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic        ready,
  output logic        sram_r_en,
  output logic        sram_w_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_w_data,
  input  logic [31:0] sram_r_data,
  input  logic        sram_ready
`ifdef MEM_CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  state_t             state_q, state_d;
  logic [31:0]        eff;
  logic [31:0]        block_base;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               wsel;
  logic               read_req, write_req;
  logic               hit, hit_way, victim_way;
  logic [31:0]        hit_word;
  logic               touch, fill_en, wr_en;
  logic [31:0]        w0_q, done_data_q;
  logic               unused_eff;

  assign eff        = address - BASE_ADDR;
  assign idx        = addr_index(eff);
  assign tag        = addr_tag(eff);
  assign wsel       = eff[WORD_SEL_BIT];
  // Clear the word-select bit in effective space, then map back.
  assign block_base = address - {29'd0, wsel, 2'b00};
  assign write_req  = mem_w_en;
  assign read_req   = mem_r_en && !mem_w_en;
  assign unused_eff = ^{eff[31:19], eff[1:0], hit_way};
  assign sram_w_data = w_data;

  mem_cache_array u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .index      (idx),
    .tag        (tag),
    .word_sel   (wsel),
    .hit        (hit),
    .hit_way    (hit_way),
    .hit_word   (hit_word),
    .victim_way (victim_way),
    .touch      (touch),
    .fill_en    (fill_en),
    .fill_word0 (w0_q),
    .fill_word1 (sram_r_data),
    .wr_en      (wr_en),
    .wr_data    (w_data)
  );

  // State register plus enables registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sram_r_en <= 1'b0;
      sram_w_en <= 1'b0;
    end else begin
      state_q   <= state_d;
      sram_r_en <= (state_d == MISS0) || (state_d == MISS1);
      sram_w_en <= (state_d == WRITE);
    end
  end

  // Next state, ready, load data, SRAM address and array strobes.
  always_comb begin
    state_d      = state_q;
    ready        = 1'b0;
    r_data       = '0;
    sram_address = address;
    touch        = 1'b0;
    fill_en      = 1'b0;
    wr_en        = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (write_req) begin
          ready   = 1'b0;
          state_d = WRITE;
        end else if (read_req) begin
          if (hit) begin
            r_data = hit_word;
            touch  = 1'b1;
          end else begin
            ready   = 1'b0;
            state_d = MISS0;
          end
        end
      end
      MISS0: begin
        sram_address = block_base;
        if (sram_ready) state_d = MISS1;
      end
      MISS1: begin
        sram_address = block_base + 32'd4;
        if (sram_ready) begin
          fill_en = 1'b1;
          state_d = DONE;
        end
      end
      WRITE: begin
        if (sram_ready) begin
          wr_en   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        ready   = 1'b1;
        r_data  = done_data_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // While held in reset the pipeline is never stalled.
    if (!rst_n) ready = 1'b1;
  end

  // Refill word capture and the word returned in DONE (zero after a write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w0_q        <= '0;
      done_data_q <= '0;
    end else begin
      if (state_q == MISS0 && sram_ready) w0_q <= sram_r_data;
      if (state_q == MISS1 && sram_ready) done_data_q <= wsel ? sram_r_data : w0_q;
      if (state_q == WRITE && sram_ready) done_data_q <= '0;
    end
  end

`ifdef MEM_CACHE_STATS_EN
  // Saturating read hit / miss counters; writes are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (touch && hit && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      if (state_q == IDLE && state_d == MISS0 && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
    end
  end
`else
  // Statistics counters not built.
`endif

endmodule

// File: tb/tb_mem_cache.sv
// tb_mem_cache: directed bench for mem_cache with a behavioral SRAM controller
// whose per-access latency is set by the stimulus.
module tb_mem_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_r_en, mem_w_en;
  logic [31:0] address, w_data, r_data;
  logic        ready, sram_r_en, sram_w_en;
  logic [31:0] sram_address, sram_w_data, sram_r_data;
  logic        sram_ready;
`ifdef MEM_CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  int checks   = 0;
  int failures = 0;
  int lat      = 1;
  int cnt      = 0;
  logic [31:0] smem [int unsigned];

  mem_cache #(.BASE_ADDR(32'd1024)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .address      (address),
    .w_data       (w_data),
    .r_data       (r_data),
    .ready        (ready),
    .sram_r_en    (sram_r_en),
    .sram_w_en    (sram_w_en),
    .sram_address (sram_address),
    .sram_w_data  (sram_w_data),
    .sram_r_data  (sram_r_data),
    .sram_ready   (sram_ready)
`ifdef MEM_CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clk = ~clk;

  // SRAM controller model: pulses sram_ready on the lat-th cycle of a request.
  initial begin
    sram_ready  = 1'b0;
    sram_r_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0; sram_ready = 1'b0;
      end else if (sram_r_en || sram_w_en) begin
        cnt++;
        if (cnt >= lat) begin
          cnt = 0;
          sram_ready = 1'b1;
          if (sram_w_en) smem[sram_address] = sram_w_data;
          else sram_r_data = smem.exists(sram_address) ? smem[sram_address] : 32'h0;
        end else begin
          sram_ready = 1'b0;
        end
      end else begin
        cnt = 0; sram_ready = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Issue a load; report cycles with ready low and the data seen when ready rises.
  task automatic do_read(input string name, input logic [31:0] a, input int l,
                         input int exp_low, input logic [31:0] exp_d);
    int low = 0; bit got = 0; logic [31:0] d = '0;
    @(posedge clk); #1;
    lat = l; mem_r_en = 1'b1; mem_w_en = 1'b0; address = a;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk); #1;
      if (ready) begin got = 1; d = r_data; end else low++;
    end
    chk({name, " completed"}, 32'(got), 32'd1);
    chk({name, " stall cycles"}, low, exp_low);
    chk({name, " r_data"}, d, exp_d);
  endtask

  // Issue a store (optionally with mem_r_en also high); sram_w_en must hold while stalled.
  task automatic do_write(input string name, input logic [31:0] a, input logic [31:0] wd,
                          input logic rd_too, input int l, input int exp_low);
    int low = 0; bit got = 0;
    @(posedge clk); #1;
    lat = l; mem_r_en = rd_too; mem_w_en = 1'b1; address = a; w_data = wd;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk); #1;
      if (ready) begin
        got = 1;
        chk({name, " sram_w_en low in DONE"}, 32'(sram_w_en), 32'd0);
      end else begin
        if (low > 0) chk({name, " sram_w_en held"}, 32'(sram_w_en), 32'd1);
        low++;
      end
    end
    chk({name, " completed"}, 32'(got), 32'd1);
    chk({name, " stall cycles"}, low, exp_low);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    mem_r_en = 1'b0; mem_w_en = 1'b0;
  endtask

  initial begin
    smem[32'd1024] = 32'hA5A5_0001; smem[32'd1028] = 32'hA5A5_0002;
    smem[32'd1536] = 32'hB0B0_0001; smem[32'd1540] = 32'hB0B0_0002;
    smem[32'd2048] = 32'hC0C0_0001; smem[32'd2052] = 32'hC0C0_0002;
    smem[32'd3000] = 32'hD0D0_0001; smem[32'd3004] = 32'hD0D0_0002;
    rst_n = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; address = '0; w_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset sram_r_en", 32'(sram_r_en), 32'd0);
    chk("reset sram_w_en", 32'(sram_w_en), 32'd0);
    chk("reset r_data", r_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Cold miss, then 0-cycle hits on both words of the block.
    do_read("miss 1024", 32'd1024, 6, 13, 32'hA5A5_0001);
    do_read("hit 1024", 32'd1024, 6, 0, 32'hA5A5_0001);
    do_read("hit 1028", 32'd1028, 6, 0, 32'hA5A5_0002);

    // Write-through hit updates the cached word.
    do_write("write 1028", 32'd1028, 32'hDEAD_BEEF, 1'b0, 4, 5);
    chk("sram holds 1028", smem[32'd1028], 32'hDEAD_BEEF);
    do_read("hit 1028 new", 32'd1028, 6, 0, 32'hDEAD_BEEF);

    // Three blocks in set 0: third fill evicts the way holding 1024.
    do_read("miss 1536", 32'd1536, 3, 7, 32'hB0B0_0001);
    do_read("miss 2048", 32'd2048, 2, 5, 32'hC0C0_0001);
    do_read("hit 1536", 32'd1536, 2, 0, 32'hB0B0_0001);
    do_read("miss 1024 evicted", 32'd1024, 1, 3, 32'hA5A5_0001);

    // Write miss (with mem_r_en also high) does not allocate.
    do_write("write 3000", 32'd3000, 32'h1234_5678, 1'b1, 2, 3);
    do_read("miss 3000", 32'd3000, 2, 5, 32'h1234_5678);
    go_idle();

    // Reset during MISS1: enables drop immediately, nothing allocated.
    @(posedge clk); #1;
    lat = 6; mem_r_en = 1'b1; address = 32'd2048;
    repeat (9) @(negedge clk);
    #1;
    chk("pre-reset sram_r_en", 32'(sram_r_en), 32'd1);
    chk("pre-reset ready", 32'(ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-miss reset sram_r_en", 32'(sram_r_en), 32'd0);
    chk("mid-miss reset ready", 32'(ready), 32'd1);
    chk("mid-miss reset r_data", r_data, 32'd0);
    mem_r_en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    do_read("reread 2048 miss", 32'd2048, 6, 13, 32'hC0C0_0001);
    do_read("stat hit 2048", 32'd2048, 6, 0, 32'hC0C0_0001);
    do_read("stat hit 2052", 32'd2052, 6, 0, 32'hC0C0_0002);
    do_read("stat hit 2048b", 32'd2048, 6, 0, 32'hC0C0_0001);
    do_read("stat miss 1024", 32'd1024, 2, 5, 32'hA5A5_0001);
    go_idle();
    @(negedge clk); #1;
`ifdef MEM_CACHE_STATS_EN
    chk("hit_count", 32'(hit_count), 32'd3);
    chk("miss_count", 32'(miss_count), 32'd2);
`endif
    chk("idle ready", 32'(ready), 32'd1);
    chk("idle r_data", r_data, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
